// File: rtl/grid_pkg.sv
// Shared definitions for the level grid: default geometry, cell-value codes,
// the width helper and the loader FSM state encoding.
package grid_pkg;

   localparam int DEF_GRID_W = 40;
   localparam int DEF_GRID_H = 30;
   localparam int DEF_CELL_W = 3;
   localparam int DEF_LEVELS = 4;

   localparam int CELL_EMPTY  = 0;
   localparam int CELL_WALL   = 1;
   localparam int CELL_PELLET = 2;
   localparam int CELL_EXIT   = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } grid_state_e;

   // Ceiling log2; returns 0 for values of 0 or 1.
   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem    = rem >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/grid_scan_counter.sv
// Raster-order x/y cell counter: x runs fastest, y steps when x wraps.
// Shared by the level loader and the renderer.
module grid_scan_counter
   import grid_pkg::*;
#(
   parameter int W = DEF_GRID_W,
   parameter int H = DEF_GRID_H,
   localparam int X_W = clog2(W),
   localparam int Y_W = clog2(H)
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           clear,
   input  logic           inc,
   output logic [X_W-1:0] x,
   output logic [Y_W-1:0] y,
   output logic           x_last,
   output logic           y_last,
   output logic           last
);

   assign x_last = (x == X_W'(W - 1));
   assign y_last = (y == Y_W'(H - 1));
   assign last   = x_last && y_last;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clock) begin
      if (reset || clear) begin
         x <= '0;
         y <= '0;
      end else if (inc) begin
         if (x_last) begin
            x <= '0;
            y <= y_last ? '0 : y + 1'b1;
         end else begin
            x <= x + 1'b1;
         end
      end
   end

endmodule

// File: rtl/grid_loader.sv
// Streams one level's cell map from a synchronous ROM into the grid RAM in raster
// order. Optional border forcing is enabled by defining GRID_LOADER_BORDER_EN.
module grid_loader
   import grid_pkg::*;
#(
   parameter int GRID_W = DEF_GRID_W,
   parameter int GRID_H = DEF_GRID_H,
   parameter int CELL_W = DEF_CELL_W,
   parameter int LEVELS = DEF_LEVELS,
   parameter logic [CELL_W-1:0] WALL_VAL = CELL_W'(CELL_WALL),
   localparam int X_W = clog2(GRID_W),
   localparam int Y_W = clog2(GRID_H),
   localparam int L_W = (clog2(LEVELS) > 1) ? clog2(LEVELS) : 1,
   localparam int A_W = clog2(LEVELS * GRID_W * GRID_H)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [L_W-1:0]    level,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [A_W-1:0]    rom_addr,
   input  logic [CELL_W-1:0] rom_data,
   output logic [X_W-1:0]    grid_x,
   output logic [Y_W-1:0]    grid_y,
   output logic [CELL_W-1:0] grid_in,
   output logic              grid_write,
   input  logic              grid_ready
);

`ifdef GRID_LOADER_BORDER_EN
   localparam bit BORDER_EN = 1'b1;
`else
   localparam bit BORDER_EN = 1'b0;
`endif

   grid_state_e       state;
   logic [L_W-1:0]    lvl;
   logic              err_q;
   logic              wr_first;
   logic [CELL_W-1:0] data_q;
   logic [CELL_W-1:0] cell_val;

   logic              accept_start;
   logic              bad_level;
   logic              scan_inc;
   logic              x_last;
   logic              y_last;
   logic              last_cell;
   logic              on_border;

   assign accept_start = (state == ST_IDLE) && start;
   assign bad_level    = (32'(level) >= LEVELS);
   assign scan_inc     = (state == ST_WRITE) && grid_ready;

   grid_scan_counter #(
      .W (GRID_W),
      .H (GRID_H)
   ) u_scan (
      .clock  (clock),
      .reset  (reset),
      .clear  (accept_start),
      .inc    (scan_inc),
      .x      (grid_x),
      .y      (grid_y),
      .x_last (x_last),
      .y_last (y_last),
      .last   (last_cell)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= ST_IDLE;
         lvl      <= '0;
         err_q    <= 1'b0;
         wr_first <= 1'b0;
         data_q   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  lvl   <= level;
                  err_q <= bad_level;
                  state <= bad_level ? ST_DONE : ST_FETCH;
               end
            end
            ST_FETCH: begin
               wr_first <= 1'b1;
               state    <= ST_WRITE;
            end
            ST_WRITE: begin
               // ROM output is only guaranteed on the first WRITE cycle; hold it for stalls.
               wr_first <= 1'b0;
               if (wr_first) begin
                  data_q <= rom_data;
               end
               if (grid_ready) begin
                  state <= last_cell ? ST_DONE : ST_FETCH;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign on_border = (grid_x == '0) || x_last || (grid_y == '0) || y_last;

   // NOTE: every variable driven in always_comb gets a default first so no
   // path leaves it unassigned and infers a latch.
   always_comb begin
      cell_val = wr_first ? rom_data : data_q;
      if (BORDER_EN && on_border) begin
         cell_val = WALL_VAL;
      end
   end

   assign rom_addr = A_W'(lvl) * A_W'(GRID_W * GRID_H)
                   + A_W'(grid_y) * A_W'(GRID_W)
                   + A_W'(grid_x);

   assign busy       = (state != ST_IDLE);
   assign done       = (state == ST_DONE);
   assign error      = (state == ST_DONE) && err_q;
   assign grid_write = (state == ST_WRITE);
   assign grid_in    = (state == ST_WRITE) ? cell_val : CELL_W'(CELL_EMPTY);

endmodule

// File: tb/tb_grid_loader.sv
// Directed bench for grid_loader: default 40x30 loads, stall, mid-load reset,
// rejected level and a small 8x4 two-level grid.
module tb_grid_loader;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_bad    = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // dut0: default 40x30, 4 levels
   logic        start0, busy0, done0, error0, grid_write0, grid_ready0;
   logic [1:0]  level0;
   logic [12:0] rom_addr0;
   logic [2:0]  rom_data0, grid_in0;
   logic [5:0]  grid_x0;
   logic [4:0]  grid_y0;

   // dut1: default grid, 3 levels
   logic        start1, busy1, done1, error1, grid_write1, grid_ready1;
   logic [1:0]  level1;
   logic [11:0] rom_addr1;
   logic [2:0]  rom_data1, grid_in1;
   logic [5:0]  grid_x1;
   logic [4:0]  grid_y1;

   // dut2: 8x4, 2 levels
   logic        start2, busy2, done2, error2, grid_write2, grid_ready2;
   logic [0:0]  level2;
   logic [5:0]  rom_addr2;
   logic [2:0]  rom_data2, grid_in2;
   logic [2:0]  grid_x2;
   logic [1:0]  grid_y2;

   grid_loader dut0 (
      .clock(clock), .reset(reset), .start(start0), .level(level0),
      .busy(busy0), .done(done0), .error(error0), .rom_addr(rom_addr0),
      .rom_data(rom_data0), .grid_x(grid_x0), .grid_y(grid_y0),
      .grid_in(grid_in0), .grid_write(grid_write0), .grid_ready(grid_ready0)
   );

   grid_loader #(.LEVELS(3)) dut1 (
      .clock(clock), .reset(reset), .start(start1), .level(level1),
      .busy(busy1), .done(done1), .error(error1), .rom_addr(rom_addr1),
      .rom_data(rom_data1), .grid_x(grid_x1), .grid_y(grid_y1),
      .grid_in(grid_in1), .grid_write(grid_write1), .grid_ready(grid_ready1)
   );

   grid_loader #(.GRID_W(8), .GRID_H(4), .LEVELS(2)) dut2 (
      .clock(clock), .reset(reset), .start(start2), .level(level2),
      .busy(busy2), .done(done2), .error(error2), .rom_addr(rom_addr2),
      .rom_data(rom_data2), .grid_x(grid_x2), .grid_y(grid_y2),
      .grid_in(grid_in2), .grid_write(grid_write2), .grid_ready(grid_ready2)
   );

   // ROM contents: large grids hold (x+y)%8 per level; small grid holds addr + addr/8.
   function automatic logic [2:0] rom_big(input int a);
      int c;
      c = a % 1200;
      return 3'(((c % 40) + (c / 40)) % 8);
   endfunction

   function automatic logic [2:0] rom_small(input int a);
      return 3'(a + a / 8);
   endfunction

   always @(posedge clock) begin
      rom_data0 <= rom_big(int'(rom_addr0));
      rom_data1 <= rom_big(int'(rom_addr1));
      rom_data2 <= rom_small(int'(rom_addr2));
   end

   // Full level-0 load on dut0, optionally stalling cell (39,0) for stall_len cycles.
   task automatic run_default(input int stall_len, input string tag);
      int c, ex, ey, nw, bad_val, busy_bad, first_w, done_c, err, cell39, stall_left;
      ex = 0; ey = 0; nw = 0; bad_val = 0; busy_bad = 0; first_w = -1;
      done_c = 0; err = 0; cell39 = 0; stall_left = stall_len;
      @(negedge clock);
      start0 = 1'b1;
      level0 = 2'd0;
      @(negedge clock);
      start0 = 1'b0;
      c = 1;
      while (done_c == 0 && c < 6000) begin
         if (busy0 !== 1'b1) busy_bad++;
         if (grid_write0 === 1'b1) begin
            if (first_w < 0) first_w = c;
            if (int'(grid_x0) != ex || int'(grid_y0) != ey ||
                int'(grid_in0) != (ex + ey) % 8 || int'(rom_addr0) != ey * 40 + ex)
               bad_val++;
            if (stall_left > 0 && ex == 39 && ey == 0) begin
               grid_ready0 = 1'b0;
               stall_left--;
            end else begin
               grid_ready0 = 1'b1;
               nw++;
               if (ex == 39 && ey == 0) cell39++;
               if (ex == 39) begin
                  ex = 0;
                  ey++;
               end else begin
                  ex++;
               end
            end
         end else begin
            grid_ready0 = 1'b1;
         end
         if (done0 === 1'b1) begin
            done_c = c;
            err    = int'(error0);
         end else begin
            @(negedge clock);
            c++;
         end
      end
      grid_ready0 = 1'b1;
      check({tag, "_writes"},    nw, 1200);
      check({tag, "_values"},    bad_val, 0);
      check({tag, "_first_wr"},  first_w, 2);
      check({tag, "_done_cyc"},  done_c, 2401 + stall_len);
      check({tag, "_busy_span"}, busy_bad, 0);
      check({tag, "_error"},     err, 0);
      check({tag, "_cell39"},    cell39, 1);
      @(negedge clock);
      check({tag, "_idle_busy"}, int'(busy0), 0);
      check({tag, "_idle_done"}, int'(done0), 0);
   endtask

   task automatic reset_mid();
      int found;
      found = 0;
      @(negedge clock);
      start0 = 1'b1;
      level0 = 2'd0;
      @(negedge clock);
      start0 = 1'b0;
      for (int i = 0; i < 1000 && found == 0; i++) begin
         if (grid_write0 === 1'b1 && int'(grid_x0) == 10 && int'(grid_y0) == 7)
            found = 1;
         else
            @(negedge clock);
      end
      check("rst_mid_reached", found, 1);
      reset = 1'b1;
      @(negedge clock);
      check("rst_mid_write", int'(grid_write0), 0);
      check("rst_mid_busy",  int'(busy0), 0);
      check("rst_mid_x",     int'(grid_x0), 0);
      reset = 1'b0;
   endtask

   task automatic reject();
      @(negedge clock);
      start1 = 1'b1;
      level1 = 2'd3;
      @(negedge clock);
      start1 = 1'b0;
      check("rej_done_c1",  int'(done1), 1);
      check("rej_error_c1", int'(error1), 1);
      check("rej_busy_c1",  int'(busy1), 1);
      check("rej_write_c1", int'(grid_write1), 0);
      @(negedge clock);
      check("rej_done_c2",  int'(done1), 0);
      check("rej_busy_c2",  int'(busy1), 0);
      check("rej_write_c2", int'(grid_write1), 0);
      // Accepted level 2; a start/level change mid-load must be ignored.
      start1 = 1'b1;
      level1 = 2'd2;
      @(negedge clock);
      start1 = 1'b0;
      check("lvl2_addr_c1", int'(rom_addr1), 2400);
      @(negedge clock);
      check("lvl2_write_c2", int'(grid_write1), 1);
      start1 = 1'b1;
      level1 = 2'd0;
      @(negedge clock);
      start1 = 1'b0;
      check("lvl2_addr_c3", int'(rom_addr1), 2401);
   endtask

   task automatic run_small();
      int c, ex, ey, nw, bad_val, done_c, amin, amax, walls, a, expv, border;
      ex = 0; ey = 0; nw = 0; bad_val = 0; done_c = 0; amin = 999; amax = -1; walls = 0;
      @(negedge clock);
      start2 = 1'b1;
      level2 = 1'b1;
      @(negedge clock);
      start2 = 1'b0;
      c = 1;
      while (done_c == 0 && c < 500) begin
         if (busy2 === 1'b1) begin
            if (int'(rom_addr2) < amin) amin = int'(rom_addr2);
            if (int'(rom_addr2) > amax) amax = int'(rom_addr2);
         end
         if (grid_write2 === 1'b1) begin
            a = 32 + ey * 8 + ex;
            border = (ex == 0 || ex == 7 || ey == 0 || ey == 3) ? 1 : 0;
`ifdef GRID_LOADER_BORDER_EN
            expv = (border != 0) ? 1 : int'(rom_small(a));
`else
            expv = int'(rom_small(a));
`endif
            if (border != 0 && int'(grid_in2) == 1) walls++;
            if (int'(grid_x2) != ex || int'(grid_y2) != ey || int'(grid_in2) != expv)
               bad_val++;
            nw++;
            if (ex == 7) begin
               ex = 0;
               ey++;
            end else begin
               ex++;
            end
         end
         if (done2 === 1'b1) begin
            done_c = c;
         end else begin
            @(negedge clock);
            c++;
         end
      end
      check("small_writes",   nw, 32);
      check("small_values",   bad_val, 0);
      check("small_done_cyc", done_c, 65);
      check("small_addr_min", amin, 32);
      check("small_addr_max", amax, 63);
      check("small_error",    int'(error2), 0);
`ifdef GRID_LOADER_BORDER_EN
      check("small_walls",    walls, 20);
`endif
      @(negedge clock);
   endtask

   initial begin
      start0 = 1'b0; level0 = '0; grid_ready0 = 1'b1;
      start1 = 1'b0; level1 = '0; grid_ready1 = 1'b1;
      start2 = 1'b0; level2 = '0; grid_ready2 = 1'b1;
      reset  = 1'b1;
      repeat (3) @(negedge clock);
      check("rst_busy",  int'(busy0), 0);
      check("rst_done",  int'(done0), 0);
      check("rst_error", int'(error0), 0);
      check("rst_write", int'(grid_write0), 0);
      check("rst_x",     int'(grid_x0), 0);
      check("rst_y",     int'(grid_y0), 0);
      check("rst_in",    int'(grid_in0), 0);
      check("rst_addr",  int'(rom_addr0), 0);
      reset = 1'b0;

      run_default(0, "load");
      run_default(5, "stall");
      reset_mid();
      run_default(0, "reload");
      reject();
      run_small();

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule

// File: doc/grid_loader.md
# grid_loader

Parametrised level loader that streams one level's cell map from a synchronous level ROM into the game grid memory, one cell at a time in raster order. It is the next-generation replacement for the fixed 40x30, 4-level loader: grid size, cell width and level count are parameters, and the grid write port has a ready handshake for backpressure. It sits between the game-control FSM (start/done) and the grid RAM write port.

## Interface
Parameters:
- GRID_W, 40, grid columns (>=2)
- GRID_H, 30, grid rows (>=2)
- CELL_W, 3, bits per cell value
- LEVELS, 4, number of levels stored in ROM (>=1)
- WALL_VAL, 3'd1, cell value forced on the border (used only with GRID_LOADER_BORDER_EN)

Derived widths (localparams):
- X_W = clog2(GRID_W)
- Y_W = clog2(GRID_H)
- L_W = max(1, clog2(LEVELS))
- A_W = clog2(LEVELS*GRID_W*GRID_H)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- level  in  L_W  level select; latched on accepted start
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when the load finishes or is rejected
- error  out  1  valid with done; 1 = level >= LEVELS, no cells written
- rom_addr  out  A_W  synchronous ROM address
- rom_data  in  CELL_W  ROM data, valid one cycle after rom_addr
- grid_x  out  X_W  cell column
- grid_y  out  Y_W  cell row
- grid_in  out  CELL_W  cell value
- grid_write  out  1  write valid
- grid_ready  in  1  grid port accepts the write this cycle

## Operation
- FSM states: IDLE, FETCH, WRITE, DONE.
- IDLE + start: latch level and zero the counters.
  - If level >= LEVELS, go to DONE with error=1.
  - Otherwise go to FETCH.
- FETCH: drive rom_addr = lvl*GRID_W*GRID_H + y*GRID_W + x, then go to WRITE.
- WRITE: assert grid_write with grid_in = registered rom_data. grid_x, grid_y and grid_in are held stable while grid_ready=0.
- On grid_write & grid_ready:
  - Last cell (x=GRID_W-1, y=GRID_H-1): go to DONE.
  - Otherwise advance x; when x wraps from GRID_W-1 to 0, increment y. Return to FETCH.
- DONE: pulse done (error valid), then return to IDLE.
- start outside IDLE is ignored. level changes after acceptance have no effect.
- Address arithmetic is unsigned at A_W bits with no overflow, since the product never exceeds the ROM depth.
- Reset at any point returns to IDLE within one cycle. No further grid_write occurs. A partially loaded grid is left as-is.
- Reset values: busy=0, done=0, error=0, grid_write=0, grid_x=0, grid_y=0, grid_in=0, rom_addr=0.

## Timing
- start sampled at cycle 0 → FETCH at cycle 1 → first grid_write at cycle 2.
- With grid_ready held high, each cell takes 2 cycles. Cell n is written at cycle 2+2n.
- With N = GRID_W*GRID_H, done pulses at cycle 2N+1. For the default N=1200, that is cycle 2401.
- Each cycle of grid_ready=0 in WRITE adds one cycle of latency.
- Rejected level: done=1 and error=1 at cycle 1; grid_write is never asserted.
- busy is high from cycle 1 through the DONE cycle inclusive.

## Configuration
- GRID_LOADER_BORDER_EN defined: cells with x=0, x=GRID_W-1, y=0 or y=GRID_H-1 are written with WALL_VAL, regardless of rom_data. ROM fetches and the cycle count are unchanged.
- Undefined: every cell is written from rom_data. WALL_VAL is unused.

## Structure
- Shared package grid_pkg holds:
  - default GRID_W/GRID_H/CELL_W/LEVELS
  - the cell-value constants (EMPTY, WALL, ...)
  - the clog2 helper
  - the FSM state enum
- One sub-module, grid_scan_counter: raster x/y counter with clear, increment and last outputs. It is reusable by the renderer.
- The FSM and address/data path stay in grid_loader.

## Test plan
- Default params, level 0, grid_ready=1, ROM models cell = (x+y)%8:
  - 1200 writes in raster order with the correct values
  - first write at cycle 2, done at cycle 2401
  - busy high for cycles 1..2401
- grid_ready low for 5 cycles on cell (39,0) → x/y/value held stable, exactly one write of that cell, done delayed by 5 cycles.
- level=3 with LEVELS=3 → done=1 and error=1 at cycle 1, no grid_write, back in IDLE at cycle 2.
- reset asserted during the write of cell (10,7) → next cycle grid_write=0 and busy=0; a subsequent start reloads from (0,0).
- GRID_W=8, GRID_H=4, LEVELS=2, level=1 → rom_addr spans 32..63; done at cycle 65.
- GRID_LOADER_BORDER_EN defined, ROM all zeros, 8x4 grid → 20 border cells = WALL_VAL, 12 interior cells = 0.
